// File: rtl/decode_pipe.sv
// decode_pipe: buffered MIPS decode stage -- instruction FIFO feeding a registered control bundle.
// Build option DECODE_HAZARD_EN: load-use stall with one-cycle bubble; undefined ties the stall low.
module decode_pipe #(
  parameter int W_CPU = 32,
  parameter int DEPTH = 4,
  parameter int W_CNT = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_CPU-1:0] in_inst,
  input  logic [W_CPU-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       wa,
  output logic [4:0]       ra1,
  output logic [4:0]       ra2,
  output logic             reg_wen,
  output logic             imm_ext,
  output logic [15:0]      imm,
  output logic [25:0]      addr,
  output logic [5:0]       alu_op,
  output logic [2:0]       pc_src,
  output logic [1:0]       mem_cmd,
  output logic             alu_src,
  output logic [1:0]       reg_src,
  output logic [W_CPU-1:0] out_pc,
  output logic             illegal,
  output logic [W_CNT-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic       WREN         = 1'b1;
  localparam logic       WDIS         = 1'b0;
  localparam logic       IMM_ZERO_EXT = 1'b0;
  localparam logic       IMM_SIGN_EXT = 1'b1;
  localparam logic       ALU_SRC_REG  = 1'b0;
  localparam logic       ALU_SRC_IMM  = 1'b1;
  localparam logic [1:0] REG_SRC_ALU  = 2'd0;
  localparam logic [1:0] REG_SRC_MEM  = 2'd1;
  localparam logic [1:0] REG_SRC_PC   = 2'd2;
  localparam logic [1:0] MEM_NOP      = 2'd0;
  localparam logic [1:0] MEM_READ     = 2'd1;
  localparam logic [1:0] MEM_WRITE    = 2'd2;
  localparam logic [2:0] PC_SRC_NEXT  = 3'd0;
  localparam logic [2:0] PC_SRC_JUMP  = 3'd1;
  localparam logic [2:0] PC_SRC_BEQ   = 3'd2;
  localparam logic [2:0] PC_SRC_BNE   = 3'd3;
  localparam logic [2:0] PC_SRC_JR    = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
  // LUI has no funct of its own; the ALU recognises this reserved code
  localparam logic [5:0] F_LUI  = 6'h3F;

  typedef struct packed {
    logic [4:0]  wa;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        reg_wen;
    logic        imm_ext;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [5:0]  alu_op;
    logic [2:0]  pc_src;
    logic [1:0]  mem_cmd;
    logic        alu_src;
    logic [1:0]  reg_src;
    logic        illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t      c;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    op = inst[31:26];
    rs = inst[25:21];
    rt = inst[20:16];
    rd = inst[15:11];
    fn = inst[5:0];
    c         = '0;
    c.reg_wen = WDIS;
    c.imm_ext = IMM_ZERO_EXT;
    c.pc_src  = PC_SRC_NEXT;
    c.mem_cmd = MEM_NOP;
    c.alu_src = ALU_SRC_REG;
    c.reg_src = REG_SRC_ALU;
    c.imm     = inst[15:0];
    c.addr    = inst[25:0];
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            c.wa = rd; c.ra1 = rs; c.ra2 = rt; c.reg_wen = WREN; c.alu_op = fn;
          end
          F_SLL, F_SRL, F_SRA: begin
            c.wa = rd; c.ra1 = rt; c.reg_wen = WREN; c.alu_op = fn;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            c.wa = rd; c.ra1 = rt; c.ra2 = rs; c.reg_wen = WREN; c.alu_op = fn;
          end
          F_JR: begin
            c.ra1 = rs; c.pc_src = PC_SRC_JR;
          end
          default: c.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.wa      = rt;
        c.ra1     = (op == OP_LUI) ? 5'd0 : rs;
        c.reg_wen = WREN;
        c.alu_src = ALU_SRC_IMM;
        case (op)
          OP_ADDI:  begin c.alu_op = F_ADD;  c.imm_ext = IMM_SIGN_EXT; end
          OP_ADDIU: begin c.alu_op = F_ADDU; c.imm_ext = IMM_SIGN_EXT; end
          OP_SLTI:  begin c.alu_op = F_SLT;  c.imm_ext = IMM_SIGN_EXT; end
          OP_SLTIU: begin c.alu_op = F_SLTU; c.imm_ext = IMM_SIGN_EXT; end
          OP_ANDI:  begin c.alu_op = F_AND;  c.imm_ext = IMM_ZERO_EXT; end
          OP_ORI:   begin c.alu_op = F_OR;   c.imm_ext = IMM_ZERO_EXT; end
          OP_XORI:  begin c.alu_op = F_XOR;  c.imm_ext = IMM_ZERO_EXT; end
          default:  begin c.alu_op = F_LUI;  c.imm_ext = IMM_ZERO_EXT; end
        endcase
      end
      OP_LW: begin
        c.wa = rt; c.ra1 = rs; c.reg_wen = WREN; c.alu_op = F_ADDU; c.alu_src = ALU_SRC_IMM;
        c.imm_ext = IMM_SIGN_EXT; c.mem_cmd = MEM_READ; c.reg_src = REG_SRC_MEM;
      end
      OP_SW: begin
        c.ra1 = rs; c.ra2 = rt; c.alu_op = F_ADDU; c.alu_src = ALU_SRC_IMM;
        c.imm_ext = IMM_SIGN_EXT; c.mem_cmd = MEM_WRITE;
      end
      OP_BEQ, OP_BNE: begin
        c.ra1 = rs; c.ra2 = rt; c.alu_op = F_SUBU; c.imm_ext = IMM_SIGN_EXT;
        c.pc_src = (op == OP_BEQ) ? PC_SRC_BEQ : PC_SRC_BNE;
      end
      OP_J:   c.pc_src = PC_SRC_JUMP;
      OP_JAL: begin
        c.wa = 5'd31; c.reg_wen = WREN; c.pc_src = PC_SRC_JUMP; c.reg_src = REG_SRC_PC;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  logic [W_CPU-1:0] inst_mem_r [DEPTH];
  logic [W_CPU-1:0] pc_mem_r   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             empty_s;
  logic             push_s;
  logic             stall_s;
  logic             advance_s;
  logic             pop_s;
  ctrl_t            head_s;

  assign in_ready  = (count != W_CNT'(DEPTH));
  assign empty_s   = (count == {W_CNT{1'b0}});
  assign push_s    = in_valid & in_ready & ~flush;
  assign head_s    = decode(inst_mem_r[rd_ptr_r][31:0]);
`ifdef DECODE_HAZARD_EN
  // unused source fields decode to 0, so a plain compare respects each class's operands
  assign stall_s   = out_valid & (mem_cmd == MEM_READ) & (wa != 5'd0) &
                     ((head_s.ra1 == wa) | (head_s.ra2 == wa));
`else
  assign stall_s   = 1'b0;
`endif
  assign advance_s = ~empty_s & (~out_valid | out_ready) & ~stall_s;
  assign pop_s     = advance_s & ~flush;

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i] <= '0;
        pc_mem_r[i]   <= '0;
      end
    end else if (push_s) begin
      inst_mem_r[wr_ptr_r] <= in_inst;
      pc_mem_r[wr_ptr_r]   <= in_pc;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count    <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_s, pop_s})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output stage: load on advance, drop valid on drain, bundle fields hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      wa        <= 5'd0;
      ra1       <= 5'd0;
      ra2       <= 5'd0;
      reg_wen   <= WDIS;
      imm_ext   <= IMM_ZERO_EXT;
      imm       <= 16'd0;
      addr      <= 26'd0;
      alu_op    <= 6'd0;
      pc_src    <= PC_SRC_NEXT;
      mem_cmd   <= MEM_NOP;
      alu_src   <= ALU_SRC_REG;
      reg_src   <= REG_SRC_ALU;
      illegal   <= 1'b0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance_s) begin
      out_valid <= 1'b1;
      wa        <= head_s.wa;
      ra1       <= head_s.ra1;
      ra2       <= head_s.ra2;
      reg_wen   <= head_s.reg_wen;
      imm_ext   <= head_s.imm_ext;
      imm       <= head_s.imm;
      addr      <= head_s.addr;
      alu_op    <= head_s.alu_op;
      pc_src    <= head_s.pc_src;
      mem_cmd   <= head_s.mem_cmd;
      alu_src   <= head_s.alu_src;
      reg_src   <= head_s.reg_src;
      illegal   <= head_s.illegal;
      out_pc    <= pc_mem_r[rd_ptr_r];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed stimulus with an instruction-queue reference model for decode_pipe.
module tb_decode_pipe;

  localparam int W_CPU = 32;
  localparam int DEPTH = 4;
  localparam int W_CNT = 3;
  localparam logic [3:0] P_OK  = 4'b1100;
`ifdef DECODE_HAZARD_EN
  localparam logic [3:0] P_HAZ = 4'b1010;
`else
  localparam logic [3:0] P_HAZ = 4'b1100;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_inst = 32'd0;
  logic [31:0]      in_pc = 32'd0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4:0]       wa, ra1, ra2;
  logic             reg_wen, imm_ext, alu_src, illegal;
  logic [15:0]      imm;
  logic [25:0]      addr;
  logic [5:0]       alu_op;
  logic [2:0]       pc_src;
  logic [1:0]       mem_cmd, reg_src;
  logic [31:0]      out_pc;
  logic [W_CNT-1:0] count;
  logic [73:0]      dut_bundle;

  decode_pipe #(.W_CPU(W_CPU), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .wa(wa), .ra1(ra1), .ra2(ra2), .reg_wen(reg_wen),
    .imm_ext(imm_ext), .imm(imm), .addr(addr), .alu_op(alu_op), .pc_src(pc_src),
    .mem_cmd(mem_cmd), .alu_src(alu_src), .reg_src(reg_src), .out_pc(out_pc),
    .illegal(illegal), .count(count)
  );

  assign dut_bundle = {wa, ra1, ra2, reg_wen, imm_ext, imm, addr, alu_op,
                       pc_src, mem_cmd, alu_src, reg_src, illegal};

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [63:0] q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Architectural meaning of each instruction, organised by instruction class
  function automatic logic [73:0] model_decode(input logic [31:0] i);
    logic [5:0] op, fn, alu;
    logic [4:0] rs, rt, rd, w, r1, r2;
    logic       wen, ext, asrc, ill;
    logic [2:0] pcs;
    logic [1:0] mem, rsrc;
    logic [5:0] itab [8];
    itab = '{6'h20, 6'h21, 6'h2A, 6'h2B, 6'h24, 6'h25, 6'h26, 6'h3F};
    op = i[31:26]; rs = i[25:21]; rt = i[20:16]; rd = i[15:11]; fn = i[5:0];
    w = 5'd0; r1 = 5'd0; r2 = 5'd0; wen = 1'b0; ext = 1'b0; asrc = 1'b0; ill = 1'b0;
    alu = 6'd0; pcs = 3'd0; mem = 2'd0; rsrc = 2'd0;
    if (op == 6'h00) begin
      if (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B}) begin w = rd; r1 = rs; r2 = rt; wen = 1'b1; alu = fn; end
      else if (fn inside {6'h00, 6'h02, 6'h03}) begin w = rd; r1 = rt; wen = 1'b1; alu = fn; end
      else if (fn inside {6'h04, 6'h06, 6'h07}) begin w = rd; r1 = rt; r2 = rs; wen = 1'b1; alu = fn; end
      else if (fn == 6'h08) begin r1 = rs; pcs = 3'd4; end
      else ill = 1'b1;
    end else if (op inside {[6'h08:6'h0F]}) begin
      w = rt; r1 = (op == 6'h0F) ? 5'd0 : rs; wen = 1'b1; asrc = 1'b1;
      ext = (op < 6'h0C); alu = itab[op[2:0]];
    end else if (op == 6'h23) begin
      w = rt; r1 = rs; wen = 1'b1; asrc = 1'b1; ext = 1'b1; alu = 6'h21; mem = 2'd1; rsrc = 2'd1;
    end else if (op == 6'h2B) begin
      r1 = rs; r2 = rt; asrc = 1'b1; ext = 1'b1; alu = 6'h21; mem = 2'd2;
    end else if (op == 6'h04 || op == 6'h05) begin
      r1 = rs; r2 = rt; ext = 1'b1; alu = 6'h23; pcs = (op == 6'h04) ? 3'd2 : 3'd3;
    end else if (op == 6'h02) begin
      pcs = 3'd1;
    end else if (op == 6'h03) begin
      w = 5'd31; wen = 1'b1; pcs = 3'd1; rsrc = 2'd2;
    end else begin
      ill = 1'b1;
    end
    return {w, r1, r2, wen, ext, i[15:0], i[25:0], alu, pcs, mem, asrc, rsrc, ill};
  endfunction

  // Compare process: staged bundle vs oldest in-flight instruction, then track the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out_valid", 1'b1, 1'b0);
        else check("bundle", {dut_bundle, out_pc}, {model_decode(q[0][63:32]), q[0][31:0]});
      end
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({in_inst, in_pc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair_test(input string name, input logic [31:0] i0, input logic [31:0] i1,
                           input logic [31:0] pc, input logic [3:0] exp_pat);
    logic [3:0] pat;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = i0; in_pc = pc; tick();
    in_inst = i1; in_pc = pc + 32'd4; tick();
    in_valid = 1'b0;
    pat[3] = out_valid; tick();
    pat[2] = out_valid; tick();
    pat[1] = out_valid; tick();
    pat[0] = out_valid;
    check(name, pat, exp_pat);
    tick(); tick();
  endtask

  logic [31:0] mix [11];
  int acc, n;
  logic rdy;

  initial begin
    mix = '{32'hAFA80004, 32'h11090003, 32'h15090003, 32'h01095004, 32'h00095080,
            32'h0C000010, 32'h08000020, 32'h03E00008, 32'h3C0B1234, 32'h310CFFFF, 32'h0000003F};

    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_bundle", dut_bundle, 74'd0);
    check("rst_out_pc", out_pc, 32'd0);
    tick();
    rst_n = 1'b1;

    // basic decode: addi $t0,$0,5
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h20080005; in_pc = 32'h100; tick();
    in_valid = 1'b0;
    check("basic_not_yet", out_valid, 1'b0);
    tick();
    check("basic_valid", out_valid, 1'b1);
    check("basic_wa", wa, 5'd8);
    check("basic_ra1", ra1, 5'd0);
    check("basic_imm", imm, 16'h0005);
    check("basic_wen", reg_wen, 1'b1);
    check("basic_ext", imm_ext, 1'b1);
    check("basic_alu", alu_op, 6'h20);
    tick(); tick();

    pair_test("lw_add_pattern", 32'h8FA80000, 32'h01084820, 32'h200, P_HAZ);
    pair_test("lw0_pattern",    32'h8FA00000, 32'h00004820, 32'h240, P_OK);
    pair_test("lw_sll_pattern", 32'h8FA80000, 32'h00084840, 32'h280, P_HAZ);
    pair_test("lw_lui_pattern", 32'h8FA80000, 32'h3C080001, 32'h2C0, P_OK);
    pair_test("lw_j_pattern",   32'h8FA80000, 32'h09000000, 32'h300, P_OK);

    // mixed classes back to back
    out_ready = 1'b1; n = 0;
    for (int k = 0; k < 15; k++) begin
      in_valid = (k < 11);
      in_inst = mix[k % 11]; in_pc = 32'h340 + 32'(4 * k);
      if (out_valid && out_ready) n++;
      tick();
    end
    in_valid = 1'b0;
    check("mix_emitted", n, 11);

    // capacity with downstream stalled
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int k = 0; k < 7; k++) begin
      in_inst = {6'h09, 5'd0, 5'(acc + 1), 16'(acc)};
      in_pc = 32'h400 + 32'(4 * acc);
      rdy = in_ready;
      tick();
      if (rdy) acc++;
    end
    in_valid = 1'b0;
    check("cap_accepted", acc, 5);
    check("cap_count", count, 3'd4);
    check("cap_in_ready", in_ready, 1'b0);
    check("cap_out_valid", out_valid, 1'b1);
    out_ready = 1'b1; n = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) n++;
      tick();
    end
    check("cap_emitted", n, 5);
    check("cap_count_after", count, 3'd0);

    // flush with 3 buffered, 1 staged, concurrent push
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_inst = {6'h0D, 5'd0, 5'(k + 10), 16'(k)}; in_pc = 32'h500 + 32'(4 * k);
      tick();
    end
    in_valid = 1'b0;
    check("flush_pre_count", count, 3'd3);
    check("flush_pre_valid", out_valid, 1'b1);
    in_valid = 1'b1; in_inst = 32'h20080077; in_pc = 32'h600; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", count, 3'd0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1; tick(); tick();
    check("flush_push_lost", out_valid, 1'b0);
    check("flush_count_after", count, 3'd0);

    // illegal opcode, then asynchronous reset between edges
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFC000000; in_pc = 32'h700; tick();
    in_inst = 32'h20080001; in_pc = 32'h704; tick();
    in_valid = 1'b0;
    check("ill_flag", illegal, 1'b1);
    check("ill_wen", reg_wen, 1'b0);
    check("ill_valid", out_valid, 1'b1);
    check("ill_count", count, 3'd1);
    #2; rst_n = 1'b0; #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_illegal", illegal, 1'b0);
    check("arst_count", count, 3'd0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_bundle", dut_bundle, 74'd0);
    check("arst_out_pc", out_pc, 32'd0);
    tick();
    rst_n = 1'b1;

    // jal after reset
    in_valid = 1'b1; in_inst = 32'h0C000010; in_pc = 32'h800; tick();
    in_valid = 1'b0; tick();
    check("jal_valid", out_valid, 1'b1);
    check("jal_wa", wa, 5'd31);
    check("jal_pc_src", pc_src, 3'd1);
    check("jal_reg_src", reg_src, 2'd2);
    out_ready = 1'b1; tick(); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
